// File: rtl/trig_pkg.sv
// Shared definitions for the trigger-bus receiver: code points, FSM encoding
// and the per-copy state bundle that the optional triplication votes on.
package trig_pkg;

  localparam logic [2:0] ENC_NONE      = 3'd0;
  localparam logic [2:0] ENC_LCT       = 3'd1;
  localparam logic [2:0] ENC_LCT_L1A   = 3'd2;
  localparam logic [2:0] ENC_LCT_L1A_M = 3'd3;
  localparam logic [2:0] ENC_L1A       = 3'd4;
  localparam logic [2:0] ENC_L1A_M     = 3'd5;
  localparam logic [2:0] ENC_ILL       = 3'd6;
  localparam logic [2:0] ENC_RSYNC     = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RQST = 2'd1,
    SYNC = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  enc;
    logic        mode;
    state_t      state;
    logic [3:0]  fcnt;
    logic        lct;
    logic        l1a;
    logic        match;
    logic        pls;
    logic        err;
    logic [11:0] bx;
    logic [23:0] l1a_cnt;
    logic [7:0]  err_cnt;
  } ctx_t;

  // Bitwise 2-of-3 vote over a whole state bundle.
  function automatic ctx_t maj3(input ctx_t a, input ctx_t b, input ctx_t c);
    return ctx_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/trig_code_dcd.sv
// Combinational decode of one registered trigger-bus code into trigger,
// resync-request and illegal-code flags, for encoded or direct mode.
module trig_code_dcd
  import trig_pkg::*;
(
  input  logic       mode,
  input  logic [2:0] enc,
  output logic       lct,
  output logic       l1a,
  output logic       match,
  output logic       rqst,
  output logic       ill
);

  always_comb begin
    lct   = 1'b0;
    l1a   = 1'b0;
    match = 1'b0;
    rqst  = 1'b0;
    ill   = 1'b0;
    if (!mode) begin
      // Direct mode: one wire per function, match mirrors L1A.
      lct   = enc[0];
      l1a   = enc[1];
      match = enc[1];
      rqst  = enc[2];
    end else begin
      case (enc)
        ENC_NONE:      ;
        ENC_LCT:       lct = 1'b1;
        ENC_LCT_L1A:   begin lct = 1'b1; l1a = 1'b1; end
        ENC_LCT_L1A_M: begin lct = 1'b1; l1a = 1'b1; match = 1'b1; end
        ENC_L1A:       l1a = 1'b1;
        ENC_L1A_M:     begin l1a = 1'b1; match = 1'b1; end
        ENC_ILL:       ill = 1'b1;
        ENC_RSYNC:     rqst = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/trig_decoder.sv
// ENC_TRG receiver: input register, code decode, resync filter FSM and the
// BX / L1A / error counters, optionally triplicated with majority voting.
module trig_decoder
  import trig_pkg::*;
#(
  parameter int BX_MAX    = 3563,
  parameter int RSYNC_MIN = 2,
  parameter int TMR       = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  ENC_TRG,
  input  logic        TRG_DCD,
  output logic        LCT,
  output logic        L1A,
  output logic        L1A_MATCH,
  output logic        RESYNC,
  output logic        RSYNC_PLS,
  output logic [11:0] BX_CNT,
  output logic [23:0] L1A_CNT,
  output logic        ERR,
  output logic [7:0]  ERR_CNT
);

  localparam int          NCOPY   = (TMR == 1) ? 3 : 1;
  localparam logic [11:0] BX_LAST = 12'(BX_MAX);
  localparam logic [3:0]  RMIN    = 4'(RSYNC_MIN);

  ctx_t ctx_all [NCOPY];
  ctx_t ctx_vote;

  generate
    if (NCOPY == 3) begin : g_vote
      assign ctx_vote = maj3(ctx_all[0], ctx_all[1], ctx_all[2]);
    end else begin : g_single
      assign ctx_vote = ctx_all[0];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NCOPY; gi++) begin : g_copy
      logic       d_lct, d_l1a, d_match, d_rqst, d_ill;
      logic [3:0] fcnt_inc;
      ctx_t       ctx_next;
      ctx_t       ctx_reg;

      trig_code_dcd u_dcd (
        .mode  (ctx_vote.mode),
        .enc   (ctx_vote.enc),
        .lct   (d_lct),
        .l1a   (d_l1a),
        .match (d_match),
        .rqst  (d_rqst),
        .ill   (d_ill)
      );

      always_comb begin
        ctx_next       = ctx_vote;
        ctx_next.enc   = ENC_TRG;
        ctx_next.mode  = TRG_DCD;
        ctx_next.lct   = 1'b0;
        ctx_next.l1a   = 1'b0;
        ctx_next.match = 1'b0;
        ctx_next.pls   = 1'b0;
        ctx_next.err   = d_ill;
        fcnt_inc       = ctx_vote.fcnt + 4'd1;

        case (ctx_vote.state)
          IDLE: begin
            if (d_rqst) begin
              ctx_next.fcnt = 4'd1;
              if (RMIN <= 4'd1) begin
                ctx_next.state = SYNC;
                ctx_next.pls   = 1'b1;
              end else begin
                ctx_next.state = RQST;
              end
            end
          end
          RQST: begin
            if (d_rqst) begin
              ctx_next.fcnt = fcnt_inc;
              if (fcnt_inc >= RMIN) begin
                ctx_next.state = SYNC;
                ctx_next.pls   = 1'b1;
              end
            end else begin
              ctx_next.state = IDLE;
              ctx_next.fcnt  = 4'd0;
            end
          end
          SYNC: begin
            if (!d_rqst) begin
              ctx_next.state = IDLE;
              ctx_next.fcnt  = 4'd0;
            end
          end
          default: begin
            ctx_next.state = IDLE;
            ctx_next.fcnt  = 4'd0;
          end
        endcase

        // Triggers only pass while idle and not on a request cycle.
        if (ctx_vote.state == IDLE && !d_rqst) begin
          ctx_next.lct   = d_lct;
          ctx_next.l1a   = d_l1a;
          ctx_next.match = d_match;
        end

        if (ctx_next.state == SYNC || ctx_vote.bx == BX_LAST) begin
          ctx_next.bx = 12'd0;
        end else begin
          ctx_next.bx = ctx_vote.bx + 12'd1;
        end

        if (ctx_next.pls) begin
          ctx_next.l1a_cnt = 24'd0;
        end else if (ctx_next.l1a) begin
          ctx_next.l1a_cnt = ctx_vote.l1a_cnt + 24'd1;
        end

        if (d_ill && ctx_vote.err_cnt != 8'hFF) begin
          ctx_next.err_cnt = ctx_vote.err_cnt + 8'd1;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          ctx_reg <= '0;
        end else begin
          ctx_reg <= ctx_next;
        end
      end

      assign ctx_all[gi] = ctx_reg;
    end
  endgenerate

  assign LCT       = ctx_vote.lct;
  assign L1A       = ctx_vote.l1a;
  assign L1A_MATCH = ctx_vote.match;
  assign RESYNC    = (ctx_vote.state == SYNC);
  assign RSYNC_PLS = ctx_vote.pls;
  assign BX_CNT    = ctx_vote.bx;
  assign L1A_CNT   = ctx_vote.l1a_cnt;
  assign ERR       = ctx_vote.err;
  assign ERR_CNT   = ctx_vote.err_cnt;

endmodule

// File: tb/tb_trig_decoder.sv
// Self-checking bench for trig_decoder: directed sequences plus randomized
// bursts, both DUT flavours (plain and triplicated) against one reference model.
module tb_trig_decoder;

  localparam int BX_MAX    = 3563;
  localparam int RSYNC_MIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  enc = 3'd0;
  logic        dcd = 1'b1;

  logic        lct, l1a, l1a_match, resync, rsync_pls, err;
  logic [11:0] bx_cnt;
  logic [23:0] l1a_cnt;
  logic [7:0]  err_cnt;

  logic        t_lct, t_l1a, t_match, t_resync, t_pls, t_err;
  logic [11:0] t_bx;
  logic [23:0] t_l1a_cnt;
  logic [7:0]  t_err_cnt;

  always #5 clk = ~clk;

  trig_decoder #(.BX_MAX(BX_MAX), .RSYNC_MIN(RSYNC_MIN), .TMR(0)) dut (
    .CLK(clk), .RST(rst), .ENC_TRG(enc), .TRG_DCD(dcd),
    .LCT(lct), .L1A(l1a), .L1A_MATCH(l1a_match), .RESYNC(resync),
    .RSYNC_PLS(rsync_pls), .BX_CNT(bx_cnt), .L1A_CNT(l1a_cnt),
    .ERR(err), .ERR_CNT(err_cnt)
  );

  trig_decoder #(.BX_MAX(BX_MAX), .RSYNC_MIN(RSYNC_MIN), .TMR(1)) dut_tmr (
    .CLK(clk), .RST(rst), .ENC_TRG(enc), .TRG_DCD(dcd),
    .LCT(t_lct), .L1A(t_l1a), .L1A_MATCH(t_match), .RESYNC(t_resync),
    .RSYNC_PLS(t_pls), .BX_CNT(t_bx), .L1A_CNT(t_l1a_cnt),
    .ERR(t_err), .ERR_CNT(t_err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts consecutive request cycles instead of tracking states.
  logic [2:0] m_enc_d  = 3'd0;
  logic       m_mode_d = 1'b0;
  int         m_run = 0;
  logic       m_lct = 0, m_l1a = 0, m_match = 0, m_resync = 0, m_pls = 0, m_err = 0;
  int         m_bx = 0, m_l1a_cnt = 0, m_err_cnt = 0;

  int n_lct, n_l1a, n_pls, n_rs, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  code;
    int  prev_run;
    bit  c_lct, c_l1a, c_match, c_rq, c_ill;
    if (rst) begin
      m_run = 0; m_lct = 0; m_l1a = 0; m_match = 0; m_resync = 0; m_pls = 0; m_err = 0;
      m_bx = 0; m_l1a_cnt = 0; m_err_cnt = 0; m_enc_d = 3'd0; m_mode_d = 1'b0;
      return;
    end
    code = int'(m_enc_d);
    if (m_mode_d) begin
      c_lct   = code inside {1, 2, 3};
      c_l1a   = code inside {2, 3, 4, 5};
      c_match = code inside {3, 5};
      c_rq    = (code == 7);
      c_ill   = (code == 6);
    end else begin
      c_lct   = (code % 2) == 1;
      c_l1a   = ((code / 2) % 2) == 1;
      c_match = c_l1a;
      c_rq    = code >= 4;
      c_ill   = 1'b0;
    end
    prev_run = m_run;
    m_run    = c_rq ? m_run + 1 : 0;
    m_resync = (m_run >= RSYNC_MIN);
    m_pls    = (m_run == RSYNC_MIN);
    m_lct    = c_lct   && !c_rq && prev_run == 0;
    m_l1a    = c_l1a   && !c_rq && prev_run == 0;
    m_match  = c_match && !c_rq && prev_run == 0;
    m_err    = c_ill;
    if (c_ill && m_err_cnt < 255) m_err_cnt++;
    m_bx = m_resync ? 0 : (m_bx + 1) % (BX_MAX + 1);
    if (m_pls) m_l1a_cnt = 0;
    else if (m_l1a) m_l1a_cnt = (m_l1a_cnt + 1) % (1 << 24);
    m_enc_d  = enc;
    m_mode_d = dcd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("lct", lct, m_lct);           chk("tmr_lct", t_lct, m_lct);
    chk("l1a", l1a, m_l1a);           chk("tmr_l1a", t_l1a, m_l1a);
    chk("match", l1a_match, m_match); chk("tmr_match", t_match, m_match);
    chk("resync", resync, m_resync);  chk("tmr_resync", t_resync, m_resync);
    chk("rsync_pls", rsync_pls, m_pls); chk("tmr_pls", t_pls, m_pls);
    chk("err", err, m_err);           chk("tmr_err", t_err, m_err);
    chk("bx_cnt", bx_cnt, m_bx);      chk("tmr_bx", t_bx, m_bx);
    chk("l1a_cnt", l1a_cnt, m_l1a_cnt); chk("tmr_l1a_cnt", t_l1a_cnt, m_l1a_cnt);
    chk("err_cnt", err_cnt, m_err_cnt); chk("tmr_err_cnt", t_err_cnt, m_err_cnt);
    if (lct)       n_lct++;
    if (l1a)       n_l1a++;
    if (rsync_pls) n_pls++;
    if (resync)    n_rs++;
    if (err)       n_err++;
  endtask

  task automatic clear_mon();
    n_lct = 0; n_l1a = 0; n_pls = 0; n_rs = 0; n_err = 0;
  endtask

  typedef struct {
    logic [2:0] code;
    logic       lct;
    logic       l1a;
    logic       match;
  } vec_t;

  vec_t vt [5];

  initial begin
    int         r;
    int         len;
    logic [2:0] code;

    vt[0] = '{3'd1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{3'd2, 1'b1, 1'b1, 1'b0};
    vt[2] = '{3'd3, 1'b1, 1'b1, 1'b1};
    vt[3] = '{3'd4, 1'b0, 1'b1, 1'b0};
    vt[4] = '{3'd5, 1'b0, 1'b1, 1'b1};

    // Reset and idle counting
    rst = 1'b1; dcd = 1'b1; enc = 3'd0;
    repeat (2) tick();
    chk("rst_lct", lct, 0);       chk("rst_resync", resync, 0);
    chk("rst_bx", bx_cnt, 0);     chk("rst_l1a_cnt", l1a_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      chk("idle_bx", bx_cnt, i);
      tick();
    end
    chk("idle_triggers", n_lct + n_l1a + n_err + n_rs, 0);

    // Encoded single-cycle codes
    for (int i = 0; i < 5; i++) begin
      enc = vt[i].code;
      tick();
      enc = 3'd0;
      chk("early_l1a", l1a, 0);
      tick();
      chk("vec_lct", lct, vt[i].lct);
      chk("vec_l1a", l1a, vt[i].l1a);
      chk("vec_match", l1a_match, vt[i].match);
      tick();
      chk("vec_pulse_end", lct | l1a | l1a_match, 0);
      repeat (2) tick();
    end
    chk("enc_l1a_cnt", l1a_cnt, 4);

    // Illegal code, error counter saturation
    clear_mon();
    for (int i = 0; i < 300; i++) begin
      enc = 3'd6; tick();
      enc = 3'd0; tick();
    end
    repeat (2) tick();
    chk("ill_err_pulses", n_err, 300);
    chk("ill_no_trig", n_lct + n_l1a, 0);
    chk("ill_err_cnt", err_cnt, 255);
    repeat (3) tick();
    chk("ill_err_cnt_hold", err_cnt, 255);

    // Resync filter: short glitch, then a long request
    clear_mon();
    enc = 3'd7; tick();
    enc = 3'd0; repeat (6) tick();
    chk("glitch_pls", n_pls, 0);
    chk("glitch_resync", n_rs, 0);
    clear_mon();
    enc = 3'd7;
    repeat (25) tick();
    chk("sync_level", resync, 1);
    chk("sync_bx", bx_cnt, 0);
    chk("sync_l1a_cnt", l1a_cnt, 0);
    enc = 3'd0;
    tick();
    chk("sync_tail", resync, 1);
    tick();
    chk("sync_end", resync, 0);
    chk("bx_resume1", bx_cnt, 1);
    tick(); chk("bx_resume2", bx_cnt, 2);
    tick(); chk("bx_resume3", bx_cnt, 3);
    chk("pls_once", n_pls, 1);
    chk("resync_len", n_rs, 24);

    // L1A immediately followed by resync
    clear_mon();
    enc = 3'd3; tick();
    enc = 3'd7; tick();
    chk("pre_rs_l1a", l1a, 1);
    chk("pre_rs_match", l1a_match, 1);
    chk("pre_rs_l1a_cnt", l1a_cnt, 1);
    repeat (24) tick();
    enc = 3'd0; repeat (4) tick();
    chk("post_rs_l1a_cnt", l1a_cnt, 0);
    chk("pre_rs_one_l1a", n_l1a, 1);

    // Direct mode
    dcd = 1'b0; enc = 3'b011; tick();
    enc = 3'd0; tick();
    chk("dir_lct", lct, 1);
    chk("dir_l1a", l1a, 1);
    chk("dir_match", l1a_match, 1);
    clear_mon();
    enc = 3'b110; tick();
    enc = 3'd0; repeat (3) tick();
    chk("dir_no_err", n_err, 0);

    // BX wrap
    for (int k = 0; k < 4000 && bx_cnt != 12'(BX_MAX); k++) tick();
    chk("bx_at_max", bx_cnt, BX_MAX);
    tick();
    chk("bx_wrap", bx_cnt, 0);

    // Reset in the middle of a resync
    dcd = 1'b1; enc = 3'd7; repeat (10) tick();
    chk("mid_rs_active", resync, 1);
    rst = 1'b1; tick();
    chk("mid_rs_resync", resync, 0);
    chk("mid_rs_bx", bx_cnt, 0);
    chk("mid_rs_err_cnt", err_cnt, 0);
    rst = 1'b0; enc = 3'd0; repeat (3) tick();

    // Randomized bursts, mode flips and occasional resets
    for (int s = 0; s < 1500; s++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end else begin
        if (r < 8) dcd = ~dcd;
        code = 3'($urandom_range(0, 7));
        len  = (code[2] && (code == 3'd7 || !dcd)) ? $urandom_range(1, 5) : 1;
        enc  = code;
        repeat (len) tick();
        enc = 3'd0;
        if ($urandom_range(0, 1) == 1) tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
